mem_stage_ctrl: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 10 +
 rtl/mem_load_ext.sv | 28 ++
 rtl/mem_stage_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared constants for the MEM stage: RV32I load/store funct3 codes and FSM states.
package mem_stage_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
endpackage

// File: rtl/mem_load_ext.sv
// Picks the addressed byte/half lane out of a read word and sign/zero extends it.
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  logic [3:0][7:0] lane;
  logic [7:0]      b;
  logic [15:0]     h;

  assign lane = rdata;
  assign b    = lane[addr_lo];
  assign h    = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    case (funct3)
      F3_B:    data = {{24{b[7]}}, b};
      F3_H:    data = {{16{h[15]}}, h};
      F3_BU:   data = {24'b0, b};
      F3_HU:   data = {16'b0, h};
      default: data = rdata;
    endcase
  end
endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: issues one bus access per EX/MEM load/store, stalls upstream until it
// completes or times out, and registers the MEM/WB outputs.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite_MEM,
  input  logic        MemtoReg_MEM,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic        Branch_MEM,
  input  logic        ZERO_MEM,
  input  logic [31:0] PC_MEM,
  input  logic [2:0]  FUNCT3_MEM,
  input  logic [31:0] ALU_OUT_MEM,
  input  logic [31:0] REG_DATA2_MEM,
  input  logic [4:0]  RD_MEM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        PCSrc,
  output logic [31:0] PC_Branch_out,
  output logic        RegWrite_WB,
  output logic        MemtoReg_WB,
  output logic [31:0] READ_DATA_WB,
  output logic [31:0] ALU_OUT_WB,
  output logic [4:0]  RD_WB,
  output logic        mem_err
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rdata_q, ext_data, wdata_d;
  logic [2:0]       f3_q;
  logic [1:0]       alo_q;
  logic [3:0]       be_d;
  logic             to_q, access, f3_ok, aligned, issue, bad, timeout_hit;

  assign PCSrc         = Branch_MEM & ZERO_MEM;
  assign PC_Branch_out = PC_MEM;

  assign access      = MemRead_MEM | MemWrite_MEM;
  assign issue       = access & f3_ok & aligned;
  assign bad         = access & ~(f3_ok & aligned);
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    f3_ok   = 1'b0;
    aligned = 1'b1;
    case (FUNCT3_MEM)
      F3_B, F3_H, F3_W: f3_ok = 1'b1;
      F3_BU, F3_HU:     f3_ok = ~MemWrite_MEM;
      default:          f3_ok = 1'b0;
    endcase
    case (FUNCT3_MEM[1:0])
      2'b01:   aligned = ~ALU_OUT_MEM[0];
      2'b10:   aligned = (ALU_OUT_MEM[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  always_comb begin
    case (FUNCT3_MEM[1:0])
      2'b00: begin
        be_d    = 4'b0001 << ALU_OUT_MEM[1:0];
        wdata_d = {4{REG_DATA2_MEM[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << {ALU_OUT_MEM[1], 1'b0};
        wdata_d = {2{REG_DATA2_MEM[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = REG_DATA2_MEM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: if (issue) begin
        stall   = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        stall = 1'b1;
        if (mem_ready || timeout_hit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A flushed pipeline must not be held by an access that reset is discarding.
    if (reset) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= '0;
      mem_wdata    <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      f3_q         <= '0;
      alo_q        <= '0;
      to_q         <= 1'b0;
      mem_err      <= 1'b0;
      RegWrite_WB  <= 1'b0;
      MemtoReg_WB  <= 1'b0;
      READ_DATA_WB <= '0;
      ALU_OUT_WB   <= '0;
      RD_WB        <= '0;
    end else begin
      mem_err <= 1'b0;
      case (state_q)
        IDLE: begin
          RegWrite_WB  <= RegWrite_MEM & ~access;
          MemtoReg_WB  <= MemtoReg_MEM & ~issue;
          RD_WB        <= RD_MEM;
          ALU_OUT_WB   <= ALU_OUT_MEM;
          READ_DATA_WB <= '0;
          mem_err      <= bad;
          if (issue) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWrite_MEM;
            mem_addr  <= {ALU_OUT_MEM[31:2], 2'b00};
            mem_be    <= be_d;
            mem_wdata <= wdata_d;
            cnt_q     <= '0;
            rdata_q   <= '0;
            f3_q      <= FUNCT3_MEM;
            alo_q     <= ALU_OUT_MEM[1:0];
            to_q      <= 1'b0;
          end
        end
        ACCESS: begin
          RegWrite_WB <= 1'b0;
          MemtoReg_WB <= 1'b0;
          cnt_q       <= cnt_q + 1'b1;
          if (mem_ready) begin
            rdata_q <= mem_rdata;
            mem_req <= 1'b0;
          end else if (timeout_hit) begin
            mem_req <= 1'b0;
            mem_err <= 1'b1;
            to_q    <= 1'b1;
          end
        end
        DONE: begin
          RegWrite_WB  <= RegWrite_MEM & ~to_q;
          MemtoReg_WB  <= MemtoReg_MEM;
          RD_WB        <= RD_MEM;
          ALU_OUT_WB   <= ALU_OUT_MEM;
          READ_DATA_WB <= mem_we ? 32'h0 : ext_data;
        end
        default: ;
      endcase
    end
  end

  mem_load_ext u_ext (
    .rdata   (rdata_q),
    .addr_lo (alo_q),
    .funct3  (f3_q),
    .data    (ext_data)
  );
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized transaction-level check of mem_stage_ctrl against a byte-lane memory-access model.
module tb_mem_stage_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0, reset;
  logic        RegWrite_MEM, MemtoReg_MEM, MemRead_MEM, MemWrite_MEM, Branch_MEM, ZERO_MEM;
  logic [31:0] PC_MEM, ALU_OUT_MEM, REG_DATA2_MEM, mem_rdata;
  logic [2:0]  FUNCT3_MEM;
  logic [4:0]  RD_MEM;
  logic        mem_req, mem_we, mem_ready, stall, PCSrc, RegWrite_WB, MemtoReg_WB, mem_err;
  logic [31:0] mem_addr, mem_wdata, PC_Branch_out, READ_DATA_WB, ALU_OUT_WB;
  logic [3:0]  mem_be;
  logic [4:0]  RD_WB;

  int checks = 0, failures = 0;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .RegWrite_MEM(RegWrite_MEM), .MemtoReg_MEM(MemtoReg_MEM), .MemRead_MEM(MemRead_MEM),
    .MemWrite_MEM(MemWrite_MEM), .Branch_MEM(Branch_MEM), .ZERO_MEM(ZERO_MEM),
    .PC_MEM(PC_MEM), .FUNCT3_MEM(FUNCT3_MEM), .ALU_OUT_MEM(ALU_OUT_MEM),
    .REG_DATA2_MEM(REG_DATA2_MEM), .RD_MEM(RD_MEM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall(stall), .PCSrc(PCSrc), .PC_Branch_out(PC_Branch_out),
    .RegWrite_WB(RegWrite_WB), .MemtoReg_WB(MemtoReg_WB), .READ_DATA_WB(READ_DATA_WB),
    .ALU_OUT_WB(ALU_OUT_WB), .RD_WB(RD_WB), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    int n;
    n = 1 << f3[1:0];
    return n;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] w);
    int nb, base;
    logic [31:0] v, mask;
    nb = nbytes(f3);
    if (nb == 4) return w;
    base = (int'(addr[1:0]) / nb) * nb;
    mask = (32'h1 << (8 * nb)) - 32'h1;
    v = (w >> (8 * base)) & mask;
    if (!f3[2] && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] addr);
    int nb, base;
    logic [3:0] be;
    nb = nbytes(f3);
    base = (int'(addr[1:0]) / nb) * nb;
    for (int i = 0; i < 4; i++) be[i] = (i >= base) && (i < base + nb);
    return be;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    int nb;
    logic [31:0] wd;
    nb = nbytes(f3);
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = d[8*(i % nb) +: 8];
    return wd;
  endfunction

  // One instruction through the stage; lat = cycles of waiting before ready (>= TO times out).
  task automatic do_instr(input logic rw, input logic mtr, input logic mr, input logic mw,
                          input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] rd, input int lat, input logic [31:0] rdata);
    logic acc, f3ok, ok, to;
    int n;
    RegWrite_MEM = rw; MemtoReg_MEM = mtr; MemRead_MEM = mr; MemWrite_MEM = mw;
    FUNCT3_MEM = f3; ALU_OUT_MEM = addr; REG_DATA2_MEM = data; RD_MEM = rd;
    Branch_MEM = 1'($urandom); ZERO_MEM = 1'($urandom); PC_MEM = $urandom;
    mem_ready = 1'b0;
    #1;
    chk("pcsrc", 32'(PCSrc), 32'(Branch_MEM & ZERO_MEM));
    chk("pc_branch", PC_Branch_out, PC_MEM);
    acc  = mr | mw;
    f3ok = mw ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    ok   = acc && f3ok && ((addr % nbytes(f3)) == 0);
    if (!ok) begin
      chk("idle_stall", 32'(stall), 32'd0);
      chk("idle_req", 32'(mem_req), 32'd0);
      if (!acc) mem_ready = 1'($urandom);
      tick;
      chk("pass_err", 32'(mem_err), 32'(acc));
      chk("pass_regwrite", 32'(RegWrite_WB), 32'(rw & ~acc));
      chk("pass_memtoreg", 32'(MemtoReg_WB), 32'(mtr));
      chk("pass_rd", 32'(RD_WB), 32'(rd));
      chk("pass_alu", ALU_OUT_WB, addr);
      chk("pass_rdata", READ_DATA_WB, 32'h0);
      chk("pass_req", 32'(mem_req), 32'd0);
    end else begin
      chk("issue_stall", 32'(stall), 32'd1);
      chk("issue_req", 32'(mem_req), 32'd0);
      tick;
      to = (lat >= TO);
      n  = to ? TO : lat + 1;
      for (int k = 0; k < n; k++) begin
        chk("acc_req", 32'(mem_req), 32'd1);
        chk("acc_stall", 32'(stall), 32'd1);
        chk("acc_bubble", 32'(RegWrite_WB), 32'd0);
        chk("acc_addr", mem_addr, {addr[31:2], 2'b00});
        chk("acc_we", 32'(mem_we), 32'(mw));
        chk("acc_be", 32'(mem_be), 32'(exp_be(f3, addr)));
        if (mw) chk("acc_wdata", mem_wdata, exp_wdata(f3, data));
        mem_ready = (k == lat);
        mem_rdata = (k == lat) ? rdata : $urandom;
        tick;
      end
      mem_ready = 1'($urandom);
      mem_rdata = $urandom;
      chk("done_req", 32'(mem_req), 32'd0);
      chk("done_stall", 32'(stall), 32'd0);
      chk("done_err", 32'(mem_err), 32'(to));
      tick;
      mem_ready = 1'b0;
      chk("wb_regwrite", 32'(RegWrite_WB), 32'(rw & ~to));
      chk("wb_memtoreg", 32'(MemtoReg_WB), 32'(mtr));
      chk("wb_rd", 32'(RD_WB), 32'(rd));
      chk("wb_alu", ALU_OUT_WB, addr);
      chk("wb_err", 32'(mem_err), 32'd0);
      if (!to) chk("wb_rdata", READ_DATA_WB, mw ? 32'h0 : load_val(f3, addr, rdata));
    end
  endtask

  initial begin
    logic [2:0] legal_f3 [5];
    legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    reset = 1'b1;
    {RegWrite_MEM, MemtoReg_MEM, MemRead_MEM, MemWrite_MEM, Branch_MEM, ZERO_MEM} = '0;
    PC_MEM = '0; FUNCT3_MEM = '0; ALU_OUT_MEM = '0; REG_DATA2_MEM = '0; RD_MEM = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    tick; tick;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_regwrite", 32'(RegWrite_WB), 32'd0);
    chk("rst_rd", 32'(RD_WB), 32'd0);
    chk("rst_alu", ALU_OUT_WB, 32'h0);
    chk("rst_rdata", READ_DATA_WB, 32'h0);
    chk("rst_err", 32'(mem_err), 32'd0);
    reset = 1'b0;

    do_instr(1, 0, 0, 0, 3'd0, 32'h1234, 32'h0, 5'd5, 0, 32'h0);
    do_instr(1, 1, 1, 0, 3'd0, 32'h103, 32'h0, 5'd7, 0, 32'h80FF_1122);
    do_instr(0, 0, 0, 1, 3'd1, 32'h202, 32'hAAAA_BEEF, 5'd0, 1, 32'h0);
    do_instr(1, 1, 1, 0, 3'd2, 32'h101, 32'h0, 5'd9, 0, 32'h0);
    do_instr(1, 1, 1, 0, 3'd2, 32'h400, 32'h0, 5'd3, 100, 32'h0);
    do_instr(1, 1, 1, 0, 3'd5, 32'h302, 32'h0, 5'd4, 2, 32'h9ABC_5678);

    // reset during the second ACCESS cycle, ready arriving afterwards
    RegWrite_MEM = 1; MemtoReg_MEM = 1; MemRead_MEM = 1; MemWrite_MEM = 0;
    FUNCT3_MEM = 3'd2; ALU_OUT_MEM = 32'h200; RD_MEM = 5'd11;
    tick; tick;
    reset = 1'b1;
    tick;
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rstacc_req", 32'(mem_req), 32'd0);
    chk("rstacc_stall", 32'(stall), 32'd0);
    chk("rstacc_regwrite", 32'(RegWrite_WB), 32'd0);
    chk("rstacc_rd", 32'(RD_WB), 32'd0);
    chk("rstacc_rdata", READ_DATA_WB, 32'h0);
    {RegWrite_MEM, MemtoReg_MEM, MemRead_MEM} = '0; RD_MEM = '0; ALU_OUT_MEM = '0;
    reset = 1'b0;
    tick;
    chk("rstacc_after_req", 32'(mem_req), 32'd0);
    chk("rstacc_after_regwrite", 32'(RegWrite_WB), 32'd0);
    mem_ready = 1'b0;

    for (int i = 0; i < 60; i++) begin
      int kind;
      logic [2:0] f3;
      kind = $urandom_range(0, 2);
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 4)];
      do_instr(1'($urandom), 1'($urandom), kind == 1, kind == 2, f3, $urandom, $urandom,
               5'($urandom), $urandom_range(0, 5), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
